// File: rtl/vm2002_pkg.sv
// Shared types and constants for the VM2002 coin path.
// Coin values are expressed in nickel units.
package vm2002_pkg;

    typedef enum logic [1:0] {
        NICKEL      = 2'd0,
        DIME        = 2'd1,
        QUARTER     = 2'd2,
        ILLEGALCOIN = 2'd3
    } coin_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        OFFER  = 2'd2,
        DONE   = 2'd3
    } chg_state_t;

    localparam logic [7:0] NICKEL_VAL  = 8'd1;
    localparam logic [7:0] DIME_VAL    = 8'd2;
    localparam logic [7:0] QUARTER_VAL = 8'd5;

    function automatic logic [7:0] coin_val(input coin_t c);
        case (c)
            QUARTER: coin_val = QUARTER_VAL;
            DIME:    coin_val = DIME_VAL;
            NICKEL:  coin_val = NICKEL_VAL;
            default: coin_val = 8'd0;
        endcase
    endfunction

endpackage

// File: rtl/vm2002_coin_select.sv
// Greedy coin picker: largest denomination that fits the remainder and is in stock.
// Purely combinational; sel_vld=0 means nothing more can be paid.
module vm2002_coin_select
    import vm2002_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic [7:0]       remaining,
    input  logic [CNT_W-1:0] n_cnt,
    input  logic [CNT_W-1:0] d_cnt,
    input  logic [CNT_W-1:0] q_cnt,
    output logic             sel_vld,
    output coin_t            sel_coin
);

    always_comb begin
        sel_vld  = 1'b0;
        sel_coin = NICKEL;
        if (remaining >= QUARTER_VAL && q_cnt != '0) begin
            sel_vld  = 1'b1;
            sel_coin = QUARTER;
        end else if (remaining >= DIME_VAL && d_cnt != '0) begin
            sel_vld  = 1'b1;
            sel_coin = DIME;
        end else if (remaining >= NICKEL_VAL && n_cnt != '0) begin
            sel_vld  = 1'b1;
            sel_coin = NICKEL;
        end
    end

endmodule

// File: rtl/vm2002_change_dispenser.sv
// Change payout engine: greedy coin selection, one coin per handshake,
// saturating inventory refills while idle, and shortfall reporting.
module vm2002_change_dispenser
    import vm2002_pkg::*;
#(
    parameter int CNT_W  = 8,
    parameter int INIT_N = 20,
    parameter int INIT_D = 20,
    parameter int INIT_Q = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             chg_req,
    input  logic [7:0]       chg_amt,
    output logic             chg_rdy,
    output logic             busy,
    output logic             coin_valid,
    output logic [1:0]       coin_type,
    input  logic             coin_ready,
    output logic             done,
    output logic [7:0]       shortfall,
    input  logic             refill_en,
    input  logic [1:0]       refill_coin,
    input  logic [CNT_W-1:0] refill_qty,
    output logic [CNT_W-1:0] n_cnt,
    output logic [CNT_W-1:0] d_cnt,
    output logic [CNT_W-1:0] q_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    chg_state_t state, nxt;
    logic [7:0] remaining;
    coin_t      coin_q;
    logic       sel_vld;
    coin_t      sel_coin;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        sat_add = s[CNT_W] ? CNT_MAX : s[CNT_W-1:0];
    endfunction

    vm2002_coin_select #(.CNT_W(CNT_W)) u_sel (
        .remaining (remaining),
        .n_cnt     (n_cnt),
        .d_cnt     (d_cnt),
        .q_cnt     (q_cnt),
        .sel_vld   (sel_vld),
        .sel_coin  (sel_coin)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt        = state;
        chg_rdy    = 1'b0;
        busy       = 1'b1;
        coin_valid = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                chg_rdy = 1'b1;
                busy    = 1'b0;
                if (chg_req) nxt = SELECT;
            end
            // sel_vld already implies remaining > 0
            SELECT: nxt = sel_vld ? OFFER : DONE;
            OFFER: begin
                coin_valid = 1'b1;
                if (coin_ready) nxt = SELECT;
            end
            DONE: begin
                done = 1'b1;
                nxt  = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            remaining <= 8'd0;
            shortfall <= 8'd0;
            coin_q    <= NICKEL;
            n_cnt     <= CNT_W'(INIT_N);
            d_cnt     <= CNT_W'(INIT_D);
            q_cnt     <= CNT_W'(INIT_Q);
        end else begin
            case (state)
                IDLE: begin
                    if (chg_req) begin
                        remaining <= chg_amt;
                        shortfall <= 8'd0;
                    end
                    if (refill_en) begin
                        case (coin_t'(refill_coin))
                            NICKEL:  n_cnt <= sat_add(n_cnt, refill_qty);
                            DIME:    d_cnt <= sat_add(d_cnt, refill_qty);
                            QUARTER: q_cnt <= sat_add(q_cnt, refill_qty);
                            default: ;
                        endcase
                    end
                end
                SELECT: begin
                    if (sel_vld) coin_q    <= sel_coin;
                    else         shortfall <= remaining;
                end
                OFFER: begin
                    if (coin_ready) begin
                        remaining <= remaining - coin_val(coin_q);
                        case (coin_q)
                            NICKEL:  n_cnt <= n_cnt - 1'b1;
                            DIME:    d_cnt <= d_cnt - 1'b1;
                            QUARTER: q_cnt <= q_cnt - 1'b1;
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    assign coin_type = coin_q;

endmodule

// File: tb/tb_vm2002_change_dispenser.sv
// Bench for vm2002_change_dispenser: directed scenarios plus randomized payouts
// against an arithmetic greedy-change model of the coin inventory.
module tb_vm2002_change_dispenser;

    localparam int CNT_W = 8;
    localparam int C_N = 0, C_D = 1, C_Q = 2, C_X = 3;
    localparam int CMAX = 255;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             chg_req;
    logic [7:0]       chg_amt;
    logic             chg_rdy;
    logic             busy;
    logic             coin_valid;
    logic [1:0]       coin_type;
    logic             coin_ready;
    logic             done;
    logic [7:0]       shortfall;
    logic             refill_en;
    logic [1:0]       refill_coin;
    logic [CNT_W-1:0] refill_qty;
    logic [CNT_W-1:0] n_cnt, d_cnt, q_cnt;

    int n_chk = 0;
    int n_err = 0;
    int inv [3];

    always #5 clk = ~clk;

    vm2002_change_dispenser #(.CNT_W(CNT_W), .INIT_N(20), .INIT_D(20), .INIT_Q(20)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .chg_req     (chg_req),
        .chg_amt     (chg_amt),
        .chg_rdy     (chg_rdy),
        .busy        (busy),
        .coin_valid  (coin_valid),
        .coin_type   (coin_type),
        .coin_ready  (coin_ready),
        .done        (done),
        .shortfall   (shortfall),
        .refill_en   (refill_en),
        .refill_coin (refill_coin),
        .refill_qty  (refill_qty),
        .n_cnt       (n_cnt),
        .d_cnt       (d_cnt),
        .q_cnt       (q_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_inv(input string tag);
        chk({tag, ".n_cnt"}, n_cnt, inv[C_N]);
        chk({tag, ".d_cnt"}, d_cnt, inv[C_D]);
        chk({tag, ".q_cnt"}, q_cnt, inv[C_Q]);
    endtask

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic apply_rf(input int c, input int q);
        if (c != C_X) inv[c] = min2(inv[c] + q, CMAX);
    endtask

    task automatic refill(input int c, input int q);
        refill_en   = 1'b1;
        refill_coin = 2'(c);
        refill_qty  = CNT_W'(q);
        @(negedge clk);
        refill_en = 1'b0;
        apply_rf(c, q);
        chk_inv("refill");
    endtask

    // One complete payout; the expected coin list is greedy change computed by division.
    task automatic payout(input int amt, input int hold, input bit rnd,
                          input bit cc_rf, input int rf_c, input int rf_q, input bit busy_rf);
        int rem, take, sf, k, idx, ocyc, budget;
        int exp_q[$];
        bit fin;
        budget = 0;
        while (!chg_rdy && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        chk("idle_wait", chg_rdy, 1);
        if (cc_rf) apply_rf(rf_c, rf_q);
        rem  = amt;
        take = min2(rem / 5, inv[C_Q]);
        repeat (take) exp_q.push_back(C_Q);
        rem -= take * 5;
        take = min2(rem / 2, inv[C_D]);
        repeat (take) exp_q.push_back(C_D);
        rem -= take * 2;
        take = min2(rem, inv[C_N]);
        repeat (take) exp_q.push_back(C_N);
        rem -= take;
        sf = rem;

        chg_req     = 1'b1;
        chg_amt     = 8'(amt);
        refill_en   = cc_rf;
        refill_coin = 2'(rf_c);
        refill_qty  = CNT_W'(rf_q);
        @(negedge clk);
        chg_req     = 1'b0;
        chg_amt     = 8'($urandom);
        refill_en   = busy_rf;
        refill_coin = 2'(C_D);
        refill_qty  = CNT_W'(5);

        k = 1; idx = 0; ocyc = 0; fin = 1'b0;
        for (budget = 0; budget < 3000 && !fin; budget++) begin
            chk_inv("pay");
            if (k == 1) begin
                chk("sel_valid", coin_valid, 0);
                chk("sel_done", done, 0);
                chk("sel_busy", busy, 1);
                coin_ready = 1'($urandom % 2);
            end else if (idx < exp_q.size()) begin
                chk("offer_valid", coin_valid, 1);
                chk("offer_type", coin_type, exp_q[idx]);
                chk("offer_rdy", chg_rdy, 0);
                if (ocyc < hold) coin_ready = 1'b0;
                else             coin_ready = rnd ? 1'($urandom % 2) : 1'b1;
                ocyc++;
                if (coin_ready) begin
                    inv[exp_q[idx]]--;
                    idx++;
                    k    = 0;
                    ocyc = 0;
                end
            end else begin
                chk("done", done, 1);
                chk("shortfall", shortfall, sf);
                chk("done_valid", coin_valid, 0);
                fin = 1'b1;
            end
            if (!fin) begin
                @(negedge clk);
                k++;
            end
        end
        if (!fin) chk("payout_timeout", 0, 1);
        coin_ready = 1'b0;
        refill_en  = 1'b0;
        @(negedge clk);
        chk("post_done", done, 0);
        chk("post_rdy", chg_rdy, 1);
        chk("post_shortfall", shortfall, sf);
        chk_inv("post");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; chg_req = 1'b0; chg_amt = '0; coin_ready = 1'b0;
        refill_en = 1'b0; refill_coin = '0; refill_qty = '0;
        inv[C_N] = 20; inv[C_D] = 20; inv[C_Q] = 20;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_rdy", chg_rdy, 1);
        chk("rst_busy", busy, 0);
        chk("rst_valid", coin_valid, 0);
        chk("rst_type", coin_type, C_N);
        chk("rst_done", done, 0);
        chk("rst_shortfall", shortfall, 0);
        chk_inv("rst");

        payout(8, 0, 1'b0, 1'b0, 0, 0, 1'b0);           // Q, D, N
        payout(0, 0, 1'b0, 1'b0, 0, 0, 1'b0);           // nothing, done at +2
        payout(5, 6, 1'b0, 1'b0, 0, 0, 1'b0);           // backpressure on a quarter
        payout(7, 0, 1'b0, 1'b0, 0, 0, 1'b1);           // dime refill while busy ignored
        payout(255, 0, 1'b1, 1'b0, 0, 0, 1'b0);         // drains every denomination
        refill(C_N, 1);
        payout(3, 0, 1'b0, 1'b0, 0, 0, 1'b0);           // one nickel, shortfall 2
        refill(C_N, 250);
        refill(C_N, 10);                                // saturates at 255
        refill(C_X, 77);                                // illegal coin ignored
        refill(C_Q, 1);
        refill(C_D, 3);
        payout(6, 0, 1'b0, 1'b1, C_N, 0, 1'b0);         // greedy: Q, then nickel
        payout(6, 0, 1'b0, 1'b1, C_Q, 2, 1'b0);         // concurrent refill seen by SELECT

        // Reset during the first offer: coin dropped, inventory back to init.
        chg_req = 1'b1; chg_amt = 8'd10;
        @(negedge clk);
        chg_req = 1'b0;
        @(negedge clk);
        chk("rstmid_valid", coin_valid, 1);
        chk("rstmid_type", coin_type, C_Q);
        coin_ready = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        coin_ready = 1'b0;
        inv[C_N] = 20; inv[C_D] = 20; inv[C_Q] = 20;
        chk("rstmid_rdy", chg_rdy, 1);
        chk("rstmid_valid0", coin_valid, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_shortfall", shortfall, 0);
        chk_inv("rstmid");
        @(negedge clk);
        chk("rstmid_idle", coin_valid, 0);

        for (int t = 0; t < 40; t++) begin
            if ($urandom % 4 == 0) refill($urandom_range(0, 3), $urandom_range(0, 255));
            payout($urandom_range(0, 60), $urandom_range(0, 3), 1'($urandom % 2),
                   ($urandom % 4 == 0), $urandom_range(0, 3), $urandom_range(0, 40),
                   ($urandom % 4 == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
